// File: rtl/analog_seq_pkg.sv
// rtl/analog_seq_pkg.sv - shared types and helpers for the analog mux sequencer
package analog_seq_pkg;

    localparam int N_CH_DEF = 6;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BREAK  = 2'd1,
        SETTLE = 2'd2,
        SAMPLE = 2'd3
    } seq_state_t;

    // Settle length in cycles; always at least one cycle.
    function automatic logic [15:0] settle_len(input logic [3:0] cfg, input int shift);
        return (16'(cfg) + 16'd1) << shift;
    endfunction

endpackage

// File: rtl/analog_seq_next_ch.sv
// rtl/analog_seq_next_ch.sv - next set bit above idx and lowest set bit of a channel mask
module analog_seq_next_ch #(
    parameter int N_CH = 6
) (
    input  logic [N_CH-1:0] mask,
    input  logic [2:0]      idx,
    output logic [2:0]      next_idx,
    output logic            found,
    output logic [2:0]      low_idx
);

    // Scan from the top down so the last hit is the lowest qualifying bit.
    always_comb begin
        next_idx = '0;
        found    = 1'b0;
        low_idx  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = 3'(i);
                if (3'(i) > idx) begin
                    next_idx = 3'(i);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/analog_mux_sequencer.sv
// rtl/analog_mux_sequencer.sv - break-before-make scan sequencer for the analog pin switches
module analog_mux_sequencer
    import analog_seq_pkg::*;
#(
    parameter int N_CH         = N_CH_DEF,
    parameter int BBM_CYC      = 2,
    parameter int SETTLE_SHIFT = 2,
    parameter int CNT_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic            start,
    input  logic            abort,
    input  logic [N_CH-1:0] chan_mask,
    input  logic [3:0]      settle_cfg,
    input  logic            cont,
    output logic [N_CH-1:0] sw_en,
    output logic            sample_stb,
    output logic [2:0]      chan_idx,
    output logic            busy,
    output logic            done,
    output logic            err_empty
);

    localparam logic [CNT_W-1:0] BBM_LOAD = CNT_W'(BBM_CYC - 1);

    seq_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_CH-1:0] mask_q, mask_d;
    logic [3:0]      cfg_q, cfg_d;
    logic [2:0]      idx_q, idx_d;
    logic            done_d, err_d;
    logic            start_q, start_prev, start_rise;

    logic [N_CH-1:0] nc_mask;
    logic [2:0]      nc_next, nc_low, nxt_idx_q;
    logic            nc_found, nxt_found_q;

    // Reset as if start were already high, so a level held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b1;
            start_prev <= 1'b1;
        end else begin
            start_q    <= start;
            start_prev <= start_q;
        end
    end
    assign start_rise = start_q & ~start_prev;

    // One search block: during SETTLE it finds the next channel of the latched mask,
    // elsewhere it finds the lowest channel of the live mask for start and wrap.
    assign nc_mask = (state_q == SETTLE) ? mask_q : chan_mask;

    analog_seq_next_ch #(.N_CH(N_CH)) u_next_ch (
        .mask     (nc_mask),
        .idx      (idx_q),
        .next_idx (nc_next),
        .found    (nc_found),
        .low_idx  (nc_low)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nxt_idx_q   <= '0;
            nxt_found_q <= 1'b0;
        end else if (state_q == SETTLE) begin
            nxt_idx_q   <= nc_next;
            nxt_found_q <= nc_found;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
        mask_d  = mask_q;
        cfg_d   = cfg_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (abort || !ena) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_rise) begin
                        if (|chan_mask) begin
                            state_d = BREAK;
                            mask_d  = chan_mask;
                            cfg_d   = settle_cfg;
                            idx_d   = nc_low;
                            cnt_d   = BBM_LOAD;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                BREAK: begin
                    if (cnt_q == '0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_W'(settle_len(cfg_q, SETTLE_SHIFT) - 16'd1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = SAMPLE;
                        cnt_d   = '0;
                    end
                end
                SAMPLE: begin
                    if (nxt_found_q) begin
                        state_d = BREAK;
                        idx_d   = nxt_idx_q;
                        cnt_d   = BBM_LOAD;
                    end else if (cont && (|chan_mask)) begin
                        state_d = BREAK;
                        mask_d  = chan_mask;
                        cfg_d   = settle_cfg;
                        idx_d   = nc_low;
                        cnt_d   = BBM_LOAD;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = cont;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            mask_q     <= '0;
            cfg_q      <= '0;
            idx_q      <= '0;
            sw_en      <= '0;
            sample_stb <= 1'b0;
            chan_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_empty  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            cfg_q      <= cfg_d;
            idx_q      <= idx_d;
            sw_en      <= (state_d == SETTLE || state_d == SAMPLE) ? (N_CH'(1) << idx_d) : '0;
            sample_stb <= (state_d == SAMPLE);
            chan_idx   <= idx_d;
            busy       <= (state_d != IDLE);
            done       <= done_d;
            err_empty  <= err_d;
        end
    end

endmodule

// File: tb/tb_analog_mux_sequencer.sv
// tb/tb_analog_mux_sequencer.sv - directed and randomized checks for analog_mux_sequencer
module tb_analog_mux_sequencer;

    localparam int BBM = 2;

    logic       clk = 1'b0;
    logic       rst_n, ena, start, abort, cont;
    logic [5:0] chan_mask;
    logic [3:0] settle_cfg;
    logic [5:0] sw_en;
    logic       sample_stb, busy, done, err_empty;
    logic [2:0] chan_idx;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    analog_mux_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .start      (start),
        .abort      (abort),
        .chan_mask  (chan_mask),
        .settle_cfg (settle_cfg),
        .cont       (cont),
        .sw_en      (sw_en),
        .sample_stb (sample_stb),
        .chan_idx   (chan_idx),
        .busy       (busy),
        .done       (done),
        .err_empty  (err_empty)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; cont = 1'b0;
        chan_mask = '0; settle_cfg = '0;
        tick(); tick();
        n_checks++;
        if ({sw_en, sample_stb, chan_idx, busy, done, err_empty} !== 13'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected all zero",
                     {sw_en, sample_stb, chan_idx, busy, done, err_empty});
        end
        rst_n = 1'b1;
        tick(); tick(); tick();
        n_checks++;
        if (busy !== 1'b0 || sw_en !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b sw_en=%b expected 0/000000", busy, sw_en);
        end
    endtask

    task automatic test_one_shot();
        logic [5:0] e_sw;
        logic [2:0] e_idx;
        logic       e_stb, e_done, e_busy;
        chan_mask = 6'b000101; settle_cfg = 4'd0; cont = 1'b0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 16; k++) begin
            tick();
            e_sw   = (k >= 3 && k <= 7) ? 6'b000001 : (k >= 10 && k <= 14) ? 6'b000100 : 6'b000000;
            e_stb  = (k == 7 || k == 14);
            e_done = (k == 15);
            e_busy = (k <= 14);
            e_idx  = (k <= 7) ? 3'd0 : 3'd2;
            n_checks += 5;
            if (sw_en !== e_sw) begin
                n_fail++; $display("FAIL oneshot_sw k=%0d: got %b expected %b", k, sw_en, e_sw);
            end
            if (sample_stb !== e_stb) begin
                n_fail++; $display("FAIL oneshot_stb k=%0d: got %b expected %b", k, sample_stb, e_stb);
            end
            if (done !== e_done) begin
                n_fail++; $display("FAIL oneshot_done k=%0d: got %b expected %b", k, done, e_done);
            end
            if (busy !== e_busy) begin
                n_fail++; $display("FAIL oneshot_busy k=%0d: got %b expected %b", k, busy, e_busy);
            end
            if (chan_idx !== e_idx) begin
                n_fail++; $display("FAIL oneshot_idx k=%0d: got %0d expected %0d", k, chan_idx, e_idx);
            end
        end
        start = 1'b0;
        tick(); tick();
    endtask

    task automatic test_empty_mask();
        chan_mask = 6'b000000;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks += 2;
            if (err_empty !== (k == 1)) begin
                n_fail++; $display("FAIL empty_err k=%0d: got %b expected %b", k, err_empty, (k == 1));
            end
            if ({busy, sample_stb, done, sw_en} !== 9'd0) begin
                n_fail++; $display("FAIL empty_quiet k=%0d: got busy=%b stb=%b done=%b sw=%b expected zeros",
                                   k, busy, sample_stb, done, sw_en);
            end
        end
        start = 1'b0;
        tick(); tick();
    endtask

    task automatic test_cont_mask_change();
        logic       e_stb;
        logic [2:0] e_idx;
        chan_mask = 6'b100001; settle_cfg = 4'd0; cont = 1'b1;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 3) chan_mask = 6'b000010;
            e_stb = (k == 7 || k == 14 || k == 21 || k == 28);
            e_idx = (k == 7) ? 3'd0 : (k == 14) ? 3'd5 : 3'd1;
            n_checks += 3;
            if (sample_stb !== e_stb) begin
                n_fail++; $display("FAIL cont_stb k=%0d: got %b expected %b", k, sample_stb, e_stb);
            end
            if (done !== 1'b0) begin
                n_fail++; $display("FAIL cont_done k=%0d: got %b expected 0", k, done);
            end
            if (busy !== 1'b1) begin
                n_fail++; $display("FAIL cont_busy k=%0d: got %b expected 1", k, busy);
            end
            if (e_stb) begin
                n_checks++;
                if (chan_idx !== e_idx) begin
                    n_fail++; $display("FAIL cont_idx k=%0d: got %0d expected %0d", k, chan_idx, e_idx);
                end
            end
            if (k == 10 || k == 17) begin
                n_checks++;
                if (sw_en !== ((k == 10) ? 6'b100000 : 6'b000010)) begin
                    n_fail++; $display("FAIL cont_sw k=%0d: got %b expected %b", k, sw_en,
                                       ((k == 10) ? 6'b100000 : 6'b000010));
                end
            end
        end
        abort = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || sw_en !== 6'd0) begin
            n_fail++; $display("FAIL cont_stop: busy=%b sw=%b expected 0/000000", busy, sw_en);
        end
        abort = 1'b0; cont = 1'b0; start = 1'b0;
        tick(); tick();
    endtask

    task automatic test_abort();
        int done_k;
        int stb_cnt;
        chan_mask = 6'b000101; settle_cfg = 4'd1; cont = 1'b0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        n_checks++;
        if (sw_en !== 6'b000100) begin
            n_fail++; $display("FAIL abort_pre_sw: got %b expected 000100", sw_en);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({sw_en, busy, done, sample_stb, chan_idx} !== {6'd0, 3'b000, 3'd2}) begin
            n_fail++; $display("FAIL abort_stop: sw=%b busy=%b done=%b stb=%b idx=%0d expected 000000/0/0/0/2",
                               sw_en, busy, done, sample_stb, chan_idx);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL abort_quiet k=%0d: done=%b busy=%b expected 0/0", k, done, busy);
            end
        end
        start = 1'b0;
        chan_mask = 6'b000010; settle_cfg = 4'd0;
        tick(); tick();
        start = 1'b1;
        tick();
        done_k = -1; stb_cnt = 0;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            tick();
            if (sample_stb) begin
                stb_cnt++;
                n_checks++;
                if (chan_idx !== 3'd1) begin
                    n_fail++; $display("FAIL abort_rescan_idx: got %0d expected 1", chan_idx);
                end
            end
            if (done) done_k = k;
        end
        n_checks += 2;
        if (done_k !== 8) begin
            n_fail++; $display("FAIL abort_rescan_done: done at cycle %0d expected 8", done_k);
        end
        if (stb_cnt !== 1) begin
            n_fail++; $display("FAIL abort_rescan_stb: got %0d strobes expected 1", stb_cnt);
        end
        start = 1'b0;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        chan_mask = 6'b000001; settle_cfg = 4'd3; cont = 1'b0;
        start = 1'b1;
        tick();
        for (int k = 1; k <= 5; k++) tick();
        n_checks++;
        if (sw_en !== 6'b000001 || busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_pre: sw=%b busy=%b expected 000001/1", sw_en, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({sw_en, sample_stb, chan_idx, busy, done, err_empty} !== 13'd0) begin
            n_fail++; $display("FAIL areset_async: got %b expected all zero",
                               {sw_en, sample_stb, chan_idx, busy, done, err_empty});
        end
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            n_checks++;
            if (busy !== 1'b0 || sw_en !== 6'd0) begin
                n_fail++; $display("FAIL areset_held_start k=%0d: busy=%b sw=%b expected 0/000000", k, busy, sw_en);
            end
        end
        start = 1'b0;
        tick(); tick();
        start = 1'b1;
        tick(); tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL areset_restart: busy=%b expected 1", busy);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        logic [5:0] prev_sw;
        int         zeros;
        logic       seen_on;
        prev_sw = sw_en; zeros = 0; seen_on = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            ena        = ($urandom_range(0, 127) != 0);
            abort      = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) start = ~start;
            chan_mask  = 6'($urandom_range(0, 63));
            settle_cfg = 4'($urandom_range(0, 3));
            cont       = ($urandom_range(0, 3) == 0);
            tick();
            n_checks += 2;
            if ($countones(sw_en) > 1) begin
                n_fail++; $display("FAIL rand_onehot c=%0d: sw=%b expected at most one set", c, sw_en);
            end
            if (sample_stb && sw_en == 6'd0) begin
                n_fail++; $display("FAIL rand_stb c=%0d: stb=1 with sw=000000 expected closed switch", c);
            end
            if (sw_en != 6'd0 && sw_en != prev_sw) begin
                if (seen_on) begin
                    n_checks++;
                    if (zeros < BBM) begin
                        n_fail++; $display("FAIL rand_bbm c=%0d: %0d open cycles expected >= %0d", c, zeros, BBM);
                    end
                end
                seen_on = 1'b1;
            end
            zeros   = (sw_en == 6'd0) ? zeros + 1 : 0;
            prev_sw = sw_en;
        end
        ena = 1'b1; abort = 1'b0; start = 1'b0; cont = 1'b0;
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_empty_mask();
        test_cont_mask_change();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
